// File: rtl/mult_pkg.sv
// Shared widths and the queued-entry layout for the multiplier result accumulator.
package mult_pkg;
  localparam int RES_W_DEF = 16;
  localparam int ACC_W_DEF = 24;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] value;
    logic                 ovf;
  } acc_entry_t;
endpackage

// File: rtl/mult_result_accum_if.sv
// Valid/ready result stream from the accumulator towards the next stage.
interface mult_result_accum_if #(parameter int ACC_W = 24) ();
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (output out_valid, output out_data, output out_ovf, input out_ready);
  modport slave  (input out_valid, input out_data, input out_ovf, output out_ready);
endinterface

// File: rtl/mult_result_accum_fifo.sv
// Small synchronous FIFO; the head output holds the last popped value while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/mult_result_accum.sv
// Turns each rising edge of the multiplier done flag into one pass-through or
// accumulated result, queued for the next stage behind a valid/ready stream.
module mult_result_accum
  import mult_pkg::*;
#(
  parameter int RES_W = RES_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RES_W-1:0]       result,
  input  logic                   d_end,
  input  logic                   acc_mode,
  input  logic                   clr_acc,
  mult_result_accum_if.master    out_if,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drop_err
);
  typedef struct packed {
    logic [ACC_W-1:0] value;
    logic             ovf;
  } entry_t;

  logic             d_end_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res_ext;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum;
  logic             capture;
  logic             pop;
  logic             full;
  logic             empty;
  entry_t           push_entry;
  entry_t           head;

  assign capture  = d_end & ~d_end_q;
  assign pop      = out_if.out_valid & out_if.out_ready;
  assign res_ext  = ACC_W'(result);
  // A same-cycle clear takes effect before the add.
  assign acc_base = clr_acc ? '0 : acc;
  assign sum      = {1'b0, acc_base} + {1'b0, res_ext};

  always_comb begin
    push_entry = '0;
    if (acc_mode) begin
      push_entry.value = sum[ACC_W-1:0];
      push_entry.ovf   = sum[ACC_W];
    end else begin
      push_entry.value = res_ext;
    end
  end

  // d_end_q resets high so a done flag already high at reset release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_end_q  <= 1'b1;
      acc      <= '0;
      drop_err <= 1'b0;
    end else begin
      d_end_q <= d_end;
      if (capture && acc_mode) acc <= sum[ACC_W-1:0];
      else if (clr_acc)        acc <= '0;
      if (capture && full && !pop) drop_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ACC_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = head.value;
  assign out_if.out_ovf   = head.ovf;
endmodule

// File: tb/tb_mult_result_accum.sv
// Directed and randomized checks of mult_result_accum against a queue-based reference.
module tb_mult_result_accum;
  localparam int RES_W = 16;
  localparam int ACC_W = 17;
  localparam int DEPTH = 4;

  typedef struct {
    longint unsigned val;
    bit              ovf;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [RES_W-1:0] result;
  logic             d_end;
  logic             acc_mode;
  logic             clr_acc;
  logic [2:0]       fifo_count;
  logic             drop_err;

  mult_result_accum_if #(.ACC_W(ACC_W)) out_if ();

  mult_result_accum #(
    .RES_W (RES_W),
    .ACC_W (ACC_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .result     (result),
    .d_end      (d_end),
    .acc_mode   (acc_mode),
    .clr_acc    (clr_acc),
    .out_if     (out_if),
    .fifo_count (fifo_count),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ent_t            q[$];
  ent_t            last;
  longint unsigned acc_m;
  bit              drop_m;
  bit              dq_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last   = '{0, 1'b0};
    acc_m  = 0;
    drop_m = 1'b0;
    dq_m   = 1'b1;
  endtask

  task automatic model_step();
    bit              cap;
    bit              pop;
    longint unsigned s;
    ent_t            e;
    if (!rst) begin
      model_reset();
      return;
    end
    cap  = d_end && !dq_m;
    dq_m = d_end;
    pop  = (q.size() != 0) && out_if.out_ready;
    e    = '{0, 1'b0};
    if (cap) begin
      if (acc_mode) begin
        s     = (clr_acc ? 0 : acc_m) + longint'(result);
        e.val = s % (longint'(1) << ACC_W);
        e.ovf = (s >= (longint'(1) << ACC_W));
        acc_m = e.val;
      end else begin
        e.val = result;
        if (clr_acc) acc_m = 0;
      end
    end else if (clr_acc) begin
      acc_m = 0;
    end
    if (pop) last = q.pop_front();
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(e);
      else drop_m = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    ent_t h;
    h = (q.size() != 0) ? q[0] : last;
    chk({tag, "_valid"}, out_if.out_valid, q.size() != 0);
    chk({tag, "_count"}, fifo_count, q.size());
    chk({tag, "_data"}, out_if.out_data, h.val);
    chk({tag, "_ovf"}, out_if.out_ovf, h.ovf);
    chk({tag, "_drop"}, drop_err, drop_m);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model("model");
  endtask

  task automatic idle();
    d_end   = 1'b0;
    clr_acc = 1'b0;
    cyc();
  endtask

  task automatic cap(input logic [RES_W-1:0] res, input logic mode, input logic clr);
    result   = res;
    acc_mode = mode;
    clr_acc  = clr;
    d_end    = 1'b1;
    cyc();
  endtask

  initial begin
    rst              = 1'b0;
    result           = '0;
    d_end            = 1'b0;
    acc_mode         = 1'b0;
    clr_acc          = 1'b0;
    out_if.out_ready = 1'b0;
    model_reset();
    #3;
    chk("reset_valid", out_if.out_valid, 0);
    chk("reset_data", out_if.out_data, 0);
    chk("reset_ovf", out_if.out_ovf, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_drop", drop_err, 0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // pass-through, single-cycle d_end
    cap(16'd25527, 1'b0, 1'b0);
    chk("pass_valid", out_if.out_valid, 1);
    chk("pass_data", out_if.out_data, 25527);
    chk("pass_ovf", out_if.out_ovf, 0);
    chk("pass_count", fifo_count, 1);
    idle();
    out_if.out_ready = 1'b1;
    cyc();

    // accumulate
    cap(16'd25527, 1'b1, 1'b0);
    chk("acc1_data", out_if.out_data, 25527);
    idle();
    cap(16'd65025, 1'b1, 1'b0);
    chk("acc2_data", out_if.out_data, 90552);
    chk("acc2_ovf", out_if.out_ovf, 0);
    idle();

    // overflow wraps at 17 bits
    cap(16'd65025, 1'b1, 1'b1);
    chk("ovf1_data", out_if.out_data, 65025);
    idle();
    cap(16'd65025, 1'b1, 1'b0);
    chk("ovf2_data", out_if.out_data, 130050);
    chk("ovf2_ovf", out_if.out_ovf, 0);
    idle();
    cap(16'd65025, 1'b1, 1'b0);
    chk("ovf3_data", out_if.out_data, 64003);
    chk("ovf3_ovf", out_if.out_ovf, 1);
    idle();

    // level d_end counts once
    out_if.out_ready = 1'b0;
    result   = 16'd4;
    acc_mode = 1'b0;
    d_end    = 1'b1;
    repeat (10) cyc();
    idle();
    chk("level_count", fifo_count, 1);
    chk("level_data", out_if.out_data, 4);
    out_if.out_ready = 1'b1;
    cyc();
    out_if.out_ready = 1'b0;

    // full and drop
    for (int i = 1; i <= 5; i++) begin
      cap(RES_W'(i), 1'b0, 1'b0);
      idle();
    end
    chk("full_count", fifo_count, 4);
    chk("full_drop", drop_err, 1);
    out_if.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", out_if.out_data, i);
      cyc();
    end
    chk("drain_empty", out_if.out_valid, 0);
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap(RES_W'(10 + i), 1'b0, 1'b0);
      idle();
    end
    out_if.out_ready = 1'b1;
    cap(16'd20, 1'b0, 1'b0);
    chk("full_pushpop_count", fifo_count, 4);
    out_if.out_ready = 1'b0;
    idle();
    out_if.out_ready = 1'b1;
    chk("pp_head0", out_if.out_data, 11);
    cyc();
    chk("pp_head1", out_if.out_data, 12);
    cyc();
    chk("pp_head2", out_if.out_data, 13);
    cyc();
    chk("pp_head3", out_if.out_data, 20);
    cyc();

    // clear together with an accumulate capture
    cap(16'd64, 1'b1, 1'b1);
    idle();
    cap(16'd16, 1'b1, 1'b1);
    chk("clr_acc_data", out_if.out_data, 16);
    chk("clr_acc_ovf", out_if.out_ovf, 0);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      result           = RES_W'($urandom_range(0, 65535));
      d_end            = 1'($urandom_range(0, 1));
      acc_mode         = 1'($urandom_range(0, 1));
      clr_acc          = ($urandom_range(0, 7) == 0);
      out_if.out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    idle();

    // reset during operation with d_end held high across release
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap(RES_W'(100 + i), 1'b0, 1'b0);
      idle();
    end
    chk("pre_rst_count", fifo_count, 3);
    result = 16'd7;
    d_end  = 1'b1;
    rst    = 1'b0;
    #1;
    model_reset();
    chk("rst_count", fifo_count, 0);
    chk("rst_valid", out_if.out_valid, 0);
    chk("rst_drop", drop_err, 0);
    cyc();
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    chk("post_rst_count", fifo_count, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_result_accum.md
Name: mult_result_accum

Overview:
- Sits directly downstream of shift_add_multiplier and consumes its 16-bit `result` / `d_end` completion output.
- Turns each completion into exactly one event.
- Each event either passes the product through or adds it into a running accumulator.
- Results are queued in a small FIFO and presented to the next stage on a valid/ready interface.

Parameters:
- RES_W, 16: width of the multiplier product input.
- ACC_W, 24: accumulator and output data width; must be at least RES_W.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- result  in  RES_W  product from the multiplier; valid while d_end = 1.
- d_end  in  1  multiplier done flag; may stay high for many cycles.
- acc_mode  in  1  1 = accumulate, 0 = pass-through; sampled on the capture cycle.
- clr_acc  in  1  synchronous clear of the accumulator.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  ACC_W  FIFO head value.
- out_ovf  out  1  overflow tag of the head entry.
- fifo_count  out  clog2(DEPTH)+1  number of occupied entries.
- drop_err  out  1  sticky: an event was lost because the FIFO was full.

Behaviour:
- Reset (rst = 0, asynchronous):
  - acc = 0, FIFO emptied, fifo_count = 0, out_valid = 0, out_data = 0, out_ovf = 0, drop_err = 0.
  - d_end_q = 1, so a d_end still high when reset deasserts is not counted.
- Edge detection: d_end_q <= d_end every cycle. A capture happens when d_end = 1 and d_end_q = 0.
  - One capture per rising edge of d_end, regardless of how long d_end stays high.
- Capture, pass-through (acc_mode = 0):
  - Push value = zero-extended result, with ovf = 0.
  - acc is unchanged.
- Capture, accumulate (acc_mode = 1):
  - sum = acc + zero-extended result, computed at ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0]; push sum[ACC_W-1:0] with ovf = sum[ACC_W]. The value wraps; there is no saturation.
- clr_acc without a capture: acc <= 0.
- clr_acc on the same cycle as an accumulate capture:
  - The clear is applied first, so acc <= result and the pushed value is result with ovf = 0.
- Latency: with the FIFO empty, a capture in cycle N gives out_valid = 1 and out_data = the value in cycle N+1.
  - There is no combinational path from d_end to out_valid.
- FIFO:
  - Pop happens when out_valid && out_ready on a clock edge.
  - out_data and out_ovf always show the head entry; when empty they hold their last value.
- Full boundary:
  - Capture with fifo_count = DEPTH and no pop that cycle: the value is dropped, drop_err <= 1 (sticky until reset), and acc is still updated.
  - Capture with fifo_count = DEPTH and a pop that cycle: the push succeeds and the count stays at DEPTH.
- Empty boundary: out_ready while empty has no effect.
- Simultaneous push and pop, not full: fifo_count is unchanged and order is preserved.
- Pointers: DEPTH is a power of two, so read/write pointers wrap naturally. fifo_count is a separate counter.
- Reset during operation: all state returns to reset values immediately, and queued entries are discarded.
- Invariant: 0 ≤ fifo_count ≤ DEPTH at all times.

Decomposition:
- Package mult_pkg holds:
  - RES_W_DEF / ACC_W_DEF constants.
  - The typedef acc_entry_t (struct of value [ACC_W-1:0] and ovf).
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated once.
- Edge detection, the accumulator and drop logic stay in the top module.

Test Plan:
- Pass-through: acc_mode = 0, result = 25527 (127×201), d_end pulsed high for 1 cycle -> one cycle later out_valid = 1, out_data = 25527, out_ovf = 0, fifo_count = 1.
- Accumulate: acc_mode = 1, results 25527 then 65025, out_ready = 1 -> outputs 25527 then 90552, both with ovf = 0.
- Overflow (ACC_W = 17): accumulate 65025 three times -> outputs 65025, 130050, then 64003 with out_ovf = 1.
- Level d_end: d_end held high for 10 cycles with result = 4 -> exactly one entry (4), fifo_count = 1.
- Full/drop: out_ready = 0, five captures of 1..5 in pass mode -> fifo_count = 4, drop_err = 1; draining then yields 1, 2, 3, 4. A further capture while full with out_ready = 1 is accepted with no new drop.
- Clear and reset:
  - clr_acc on the same cycle as an accumulate capture of 16, with acc = 64 -> pushed value 16.
  - Asserting rst while 3 entries are queued -> fifo_count = 0, out_valid = 0, drop_err = 0, and no capture while d_end stays high after release.
